// File: rtl/conv_loop1_multi_ch_engine.sv
// ============================================================================
// Module      : conv_loop1_multi_ch_engine
// Description : Kernel-loop MAC engine, PIX pixels x POF channels, one tap/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_loop1_multi_ch_engine #(
    parameter int KX  = 3,
    parameter int KY  = 3,
    parameter int PIX = 4,
    parameter int POF = 2,
    parameter int RES = 8,
    parameter int ACC = 24
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           abort,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [KY*(PIX+KX-1)*RES-1:0]                   row_buf,
    input  logic [POF*KX*KY*RES-1:0]                       weights,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [POF*PIX*ACC-1:0]                         acc_out,
    output logic [((KX*KY > 1) ? $clog2(KX*KY) : 1)-1:0]   tap_idx,
    output logic                                           busy
);

    localparam int c_ROWW = PIX + KX - 1;
    localparam int c_TAPS = KX * KY;
    localparam int c_TW   = (c_TAPS > 1) ? $clog2(c_TAPS) : 1;
    localparam int c_KXW  = (KX > 1) ? $clog2(KX) : 1;
    localparam int c_KYW  = (KY > 1) ? $clog2(KY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MAC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [KY*c_ROWW*RES-1:0]    r_row;
    logic [POF*c_TAPS*RES-1:0]   r_wts;
    logic [POF*PIX*ACC-1:0]      r_acc;
    logic [POF*PIX*ACC-1:0]      w_acc_next;
    logic [c_KXW-1:0]            r_kx;
    logic [c_KYW-1:0]            r_ky;
    logic [c_TW-1:0]             r_tap;
    logic                        w_accept;
    logic                        w_last_tap;

    assign w_accept   = (r_state == S_IDLE) && in_valid && !abort;
    assign w_last_tap = (r_tap == c_TW'(c_TAPS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)   w_state_next = S_LOAD;
            S_LOAD:                 w_state_next = S_MAC;
            S_MAC:  if (w_last_tap) w_state_next = S_DONE;
            S_DONE: if (out_ready)  w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
        if (abort) begin
            w_state_next = S_IDLE;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_LOAD) || (r_state == S_MAC);
    assign tap_idx   = r_tap;
    assign acc_out   = r_acc;

    // One multiplier per (channel, pixel); the tap counters select the operands.
    for (genvar o = 0; o < POF; o++) begin : g_ch
        for (genvar p = 0; p < PIX; p++) begin : g_pix
            logic signed [RES-1:0]   w_pix;
            logic signed [RES-1:0]   w_wt;
            logic signed [2*RES-1:0] w_prod;

            assign w_pix  = r_row[(int'(r_ky) * c_ROWW + int'(r_kx) + p) * RES +: RES];
            assign w_wt   = r_wts[(o * c_TAPS + int'(r_tap)) * RES +: RES];
            assign w_prod = w_pix * w_wt;
            assign w_acc_next[(o*PIX+p)*ACC +: ACC] =
                r_acc[(o*PIX+p)*ACC +: ACC] + ACC'(w_prod);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row <= '0;
            r_wts <= '0;
            r_acc <= '0;
            r_kx  <= '0;
            r_ky  <= '0;
            r_tap <= '0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_acc <= '0;
            r_kx  <= '0;
            r_ky  <= '0;
            r_tap <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_row <= row_buf;
                        r_wts <= weights;
                        r_acc <= '0;
                    end
                end
                S_LOAD: begin
                    r_kx  <= '0;
                    r_ky  <= '0;
                    r_tap <= '0;
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (w_last_tap) begin
                        r_kx  <= '0;
                        r_ky  <= '0;
                        r_tap <= '0;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                        if (r_kx == c_KXW'(KX - 1)) begin
                            r_kx <= '0;
                            r_ky <= r_ky + 1'b1;
                        end else begin
                            r_kx <= r_kx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_loop1_multi_ch_engine.sv
// ============================================================================
// Module      : tb_conv_loop1_multi_ch_engine
// Description : Directed bench with a window-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_loop1_multi_ch_engine;

    localparam int c_KX   = 3;
    localparam int c_KY   = 3;
    localparam int c_PIX  = 4;
    localparam int c_POF  = 2;
    localparam int c_RES  = 8;
    localparam int c_ACC  = 24;
    localparam int c_ROWW = c_PIX + c_KX - 1;
    localparam int c_TAPS = c_KX * c_KY;
    localparam int c_TW   = $clog2(c_TAPS);

    logic                            clk = 1'b0;
    logic                            rst_n = 1'b0;
    logic                            abort = 1'b0;
    logic                            in_valid = 1'b0;
    logic                            in_ready;
    logic [c_KY*c_ROWW*c_RES-1:0]    row_buf = '0;
    logic [c_POF*c_TAPS*c_RES-1:0]   weights = '0;
    logic                            out_valid;
    logic                            out_ready = 1'b0;
    logic [c_POF*c_PIX*c_ACC-1:0]    acc_out;
    logic [c_TW-1:0]                 tap_idx;
    logic                            busy;

    int checks = 0;
    int errors = 0;

    conv_loop1_multi_ch_engine #(
        .KX(c_KX), .KY(c_KY), .PIX(c_PIX), .POF(c_POF), .RES(c_RES), .ACC(c_ACC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .row_buf(row_buf), .weights(weights),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .tap_idx(tap_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    // Window-level model: m_age counts edges since the accept edge.
    bit                 m_act = 1'b0;
    int                 m_age = 0;
    int                 m_row [c_KY][c_ROWW];
    int                 m_w   [c_POF][c_TAPS];
    logic [c_ACC-1:0]   m_hold[c_POF][c_PIX];

    function automatic logic [c_ACC-1:0] tap_sum(int o, int p, int n);
        longint s = 0;
        for (int t = 0; t < n; t++)
            s += longint'(m_row[t / c_KX][p + t % c_KX]) * longint'(m_w[o][t]);
        return c_ACC'(s);
    endfunction

    task automatic model_clear_hold();
        for (int o = 0; o < c_POF; o++)
            for (int p = 0; p < c_PIX; p++)
                m_hold[o][p] = '0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_act = 1'b0;
            model_clear_hold();
            for (int r = 0; r < c_KY; r++)
                for (int c = 0; c < c_ROWW; c++) m_row[r][c] = 0;
            for (int o = 0; o < c_POF; o++)
                for (int t = 0; t < c_TAPS; t++) m_w[o][t] = 0;
        end else if (m_act && abort) begin
            m_act = 1'b0;
            model_clear_hold();
        end else if (!m_act) begin
            if (in_valid && !abort) begin
                for (int r = 0; r < c_KY; r++)
                    for (int c = 0; c < c_ROWW; c++)
                        m_row[r][c] = int'($signed(row_buf[(r*c_ROWW+c)*c_RES +: c_RES]));
                for (int o = 0; o < c_POF; o++)
                    for (int t = 0; t < c_TAPS; t++)
                        m_w[o][t] = int'($signed(weights[(o*c_TAPS+t)*c_RES +: c_RES]));
                m_act = 1'b1;
                m_age = 0;
            end
        end else if (m_age > c_TAPS && out_ready) begin
            for (int o = 0; o < c_POF; o++)
                for (int p = 0; p < c_PIX; p++)
                    m_hold[o][p] = tap_sum(o, p, c_TAPS);
            m_act = 1'b0;
        end else begin
            m_age++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        logic [c_POF*c_PIX*c_ACC-1:0] e_acc;
        logic e_ir, e_ov, e_busy;
        int   e_tap;
        #1;
        e_ir = !m_act;
        e_ov = m_act && (m_age > c_TAPS);
        e_busy = m_act && (m_age <= c_TAPS);
        e_tap = (m_act && m_age >= 1 && m_age <= c_TAPS) ? m_age - 1 : 0;
        for (int o = 0; o < c_POF; o++)
            for (int p = 0; p < c_PIX; p++) begin
                if (!m_act)
                    e_acc[(o*c_PIX+p)*c_ACC +: c_ACC] = m_hold[o][p];
                else if (m_age == 0)
                    e_acc[(o*c_PIX+p)*c_ACC +: c_ACC] = '0;
                else if (m_age <= c_TAPS)
                    e_acc[(o*c_PIX+p)*c_ACC +: c_ACC] = tap_sum(o, p, m_age - 1);
                else
                    e_acc[(o*c_PIX+p)*c_ACC +: c_ACC] = tap_sum(o, p, c_TAPS);
            end
        checks++;
        if (in_ready !== e_ir || out_valid !== e_ov || busy !== e_busy ||
            int'(tap_idx) != e_tap || acc_out !== e_acc) begin
            errors++;
            $display("FAIL model: got ir=%b ov=%b busy=%b tap=%0d acc=%h expected ir=%b ov=%b busy=%b tap=%0d acc=%h at %0t",
                     in_ready, out_valid, busy, tap_idx, acc_out,
                     e_ir, e_ov, e_busy, e_tap, e_acc, $time);
        end
    end

    function automatic longint acc_at(int o, int p);
        return longint'($signed(acc_out[(o*c_PIX+p)*c_ACC +: c_ACC]));
    endfunction

    task automatic fill_uniform(input int pv, input int wv);
        for (int i = 0; i < c_KY*c_ROWW; i++) row_buf[i*c_RES +: c_RES] = c_RES'(pv);
        for (int i = 0; i < c_POF*c_TAPS; i++) weights[i*c_RES +: c_RES] = c_RES'(wv);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < c_KY; r++)
            for (int c = 0; c < c_ROWW; c++) row_buf[(r*c_ROWW+c)*c_RES +: c_RES] = c_RES'(c);
        weights = '0;
        weights[(0*c_TAPS + 1*c_KX + 2)*c_RES +: c_RES] = 8'd1;
    endtask

    // Accept one window and wait (bounded) for out_valid; returns edges after accept.
    task automatic run_window(output int lat);
        @(negedge clk) in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk) in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic release_out();
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
    endtask

    task automatic wait_tap(input int t);
        int n = 0;
        while (!(busy && int'(tap_idx) == t) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_tap", longint'(tap_idx), longint'(t));
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_acc", longint'(acc_out != 0), 0);

        // Reset in the middle of MAC
        fill_uniform(3, 2);
        @(negedge clk) in_valid = 1'b1;
        @(negedge clk) in_valid = 1'b0;
        wait_tap(4);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("rst_mid_in_ready", longint'(in_ready), 1);
        chk("rst_mid_out_valid", longint'(out_valid), 0);
        chk("rst_mid_acc", longint'(acc_out != 0), 0);
        chk("rst_mid_tap", longint'(tap_idx), 0);

        // All ones
        fill_uniform(1, 1);
        run_window(lat);
        chk("ones_latency", lat, 10);
        for (int o = 0; o < c_POF; o++)
            for (int p = 0; p < c_PIX; p++) chk("ones_acc", acc_at(o, p), 9);
        release_out();

        // Signed extremes
        fill_uniform(-128, -128);
        run_window(lat);
        chk("neg_neg_acc0", acc_at(0, 0), 147456);
        chk("neg_neg_acc7", acc_at(1, 3), 147456);
        release_out();
        fill_uniform(-128, 127);
        run_window(lat);
        chk("neg_pos_acc0", acc_at(0, 0), -146304);
        chk("neg_pos_acc5", acc_at(1, 1), -146304);
        release_out();

        // Ramp, single tap weight
        fill_ramp();
        run_window(lat);
        for (int p = 0; p < c_PIX; p++) begin
            chk("ramp_ch0", acc_at(0, p), p + 2);
            chk("ramp_ch1", acc_at(1, p), 0);
        end
        release_out();

        // Back-pressure in DONE, stray in_valid ignored
        fill_uniform(2, 3);
        run_window(lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = i[0];
            fill_uniform(i, 1);
        end
        in_valid = 1'b0;
        chk("hold_out_valid", longint'(out_valid), 1);
        chk("hold_in_ready", longint'(in_ready), 0);
        chk("hold_acc", acc_at(0, 2), 54);
        out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
        chk("release_in_ready", longint'(in_ready), 1);
        chk("release_keep_acc", acc_at(1, 0), 54);
        fill_uniform(1, -1);
        run_window(lat);
        chk("after_hold_acc", acc_at(0, 1), -9);
        release_out();

        // Abort at tap 3 with in_valid high
        fill_uniform(5, 5);
        @(negedge clk) in_valid = 1'b1;
        @(negedge clk) in_valid = 1'b0;
        wait_tap(3);
        abort = 1'b1;
        in_valid = 1'b1;
        fill_uniform(1, 2);
        @(negedge clk) abort = 1'b0;
        chk("abort_in_ready", longint'(in_ready), 1);
        chk("abort_acc", longint'(acc_out != 0), 0);
        @(negedge clk) in_valid = 1'b0;
        chk("abort_then_accept", longint'(busy), 1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("abort_window_acc", acc_at(1, 3), 18);
        release_out();

        // Abort in IDLE blocks accept
        @(negedge clk);
        abort = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        chk("idle_abort_block", longint'(in_ready), 1);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
